// File: rtl/mem_rd_arbiter_pkg.sv
// Shared constants for the two-master memory read arbiter: bus width defaults,
// FSM state encoding and owner encoding.
package mem_rd_arbiter_pkg;

  localparam int MemAddrBus = 32;
  localparam int MemDataBus = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2
  } arb_state_e;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

endpackage

// File: rtl/mem_rd_arbiter_if.sv
// One AXI-lite read channel (AR + R). The master modport issues reads,
// the slave modport answers them.
interface mem_rd_arbiter_if
  import mem_rd_arbiter_pkg::*;
#(
  parameter int ADDR_W = MemAddrBus,
  parameter int DATA_W = MemDataBus
);

  logic              arvalid;
  logic [ADDR_W-1:0] araddr;
  logic              arready;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  logic              rready;

  modport master (
    output arvalid, araddr, rready,
    input  arready, rvalid, rdata
  );

  modport slave (
    input  arvalid, araddr, rready,
    output arready, rvalid, rdata
  );

endinterface

// File: rtl/mem_rd_arbiter_arb_pick2.sv
// Combinational two-request picker. Fixed LSU-over-IFU priority by default;
// round-robin against rr_last when MEM_RD_ARB_RR_EN is defined.
module arb_pick2
  import mem_rd_arbiter_pkg::*;
(
  input  logic req_if,
  input  logic req_ls,
`ifdef MEM_RD_ARB_RR_EN
  input  logic rr_last,
`endif
  output logic gnt_vld,
  output logic gnt
);

  always_comb begin
    gnt_vld = req_if | req_ls;
`ifdef MEM_RD_ARB_RR_EN
    // On a tie the master that did not complete last goes first.
    if (req_if && req_ls) begin
      gnt = ~rr_last;
    end else begin
      gnt = req_ls ? OWN_LS : OWN_IF;
    end
`else
    gnt = req_ls ? OWN_LS : OWN_IF;
`endif
  end

endmodule

// File: rtl/mem_rd_arbiter.sv
// Two-master (IFU, LSU) to one-slave AXI-lite read arbiter, one read in flight.
// Optional round-robin arbitration via `define MEM_RD_ARB_RR_EN.
module mem_rd_arbiter
  import mem_rd_arbiter_pkg::*;
#(
  parameter int ADDR_W = MemAddrBus,
  parameter int DATA_W = MemDataBus
) (
  input  logic             clk,
  input  logic             rst,
  mem_rd_arbiter_if.slave  ifu,
  mem_rd_arbiter_if.slave  lsu,
  mem_rd_arbiter_if.master mem
);

  arb_state_e state;
  logic       owner;
  logic       gnt_vld;
  logic       gnt;

  logic              own_arvalid;
  logic [ADDR_W-1:0] own_araddr;
  logic              own_rready;
  logic              in_ar;
  logic              in_r;

`ifdef MEM_RD_ARB_RR_EN
  logic rr_last;
`endif

  arb_pick2 u_pick (
    .req_if  (ifu.arvalid),
    .req_ls  (lsu.arvalid),
`ifdef MEM_RD_ARB_RR_EN
    .rr_last (rr_last),
`endif
    .gnt_vld (gnt_vld),
    .gnt     (gnt)
  );

  assign in_ar       = (state == AR);
  assign in_r        = (state == R);
  assign own_arvalid = (owner == OWN_LS) ? lsu.arvalid : ifu.arvalid;
  assign own_araddr  = (owner == OWN_LS) ? lsu.araddr  : ifu.araddr;
  assign own_rready  = (owner == OWN_LS) ? lsu.rready  : ifu.rready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= OWN_IF;
`ifdef MEM_RD_ARB_RR_EN
      rr_last <= OWN_IF;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (gnt_vld) begin
            owner <= gnt;
            state <= AR;
          end
        end
        AR: begin
          // Owner withdrawing its request abandons the grant without a slave beat.
          if (!own_arvalid) begin
            state <= IDLE;
          end else if (mem.arready) begin
            state <= R;
          end
        end
        R: begin
          if (mem.rvalid && own_rready) begin
            state <= IDLE;
`ifdef MEM_RD_ARB_RR_EN
            rr_last <= owner;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Channel routing is gated by the registered state, so nothing reaches the
  // slave in the same cycle a request is first seen.
  assign mem.arvalid = in_ar & own_arvalid;
  assign mem.araddr  = in_ar ? own_araddr : '0;
  assign mem.rready  = in_r & own_rready;

  assign ifu.arready = in_ar & (owner == OWN_IF) & mem.arready;
  assign lsu.arready = in_ar & (owner == OWN_LS) & mem.arready;

  assign ifu.rvalid  = in_r & (owner == OWN_IF) & mem.rvalid;
  assign lsu.rvalid  = in_r & (owner == OWN_LS) & mem.rvalid;
  assign ifu.rdata   = in_r ? mem.rdata : '0;
  assign lsu.rdata   = in_r ? mem.rdata : '0;

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Directed bench for mem_rd_arbiter: per-cycle vector table plus streaming
// and contention sequences.
module tb_mem_rd_arbiter;
  import mem_rd_arbiter_pkg::*;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
  localparam logic [31:0] Z  = 32'h0;
  localparam logic [31:0] A0 = 32'h8000_0000;
  localparam logic [31:0] A4 = 32'h8000_0004;
  localparam logic [31:0] A8 = 32'h8000_0008;
  localparam logic [31:0] AC = 32'h8000_000C;
  localparam logic [31:0] LA = 32'h8000_1000;
  localparam logic [31:0] LB = 32'h8000_2000;
  localparam logic [63:0] ZD = 64'h0;
  localparam logic [63:0] D0 = 64'h0000_0013_0010_0093;
  localparam logic [63:0] D1 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] D2 = 64'h5555_6666_7777_8888;
  localparam logic [63:0] D3 = 64'h9999_AAAA_BBBB_CCCC;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_rd_arbiter_if ifu_bus ();
  mem_rd_arbiter_if lsu_bus ();
  mem_rd_arbiter_if mem_bus ();

  mem_rd_arbiter dut (
    .clk (clk),
    .rst (rst),
    .ifu (ifu_bus),
    .lsu (lsu_bus),
    .mem (mem_bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    string       name;
    logic        rst, ifv;
    logic [31:0] ifa;
    logic        ifr, lsv;
    logic [31:0] lsa;
    logic        lsr, sar, srv;
    logic [63:0] srd;
    logic        e_sav;
    logic [31:0] e_saa;
    logic        e_srr, e_ifar, e_lsar, e_ifrv, e_lsrv;
    logic [63:0] e_rd;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string n, input logic r, ifv, input logic [31:0] ifa,
                     input logic ifr, lsv, input logic [31:0] lsa, input logic lsr, sar, srv,
                     input logic [63:0] srd, input logic esav, input logic [31:0] esaa,
                     input logic esrr, eifar, elsar, eifrv, elsrv, input logic [63:0] erd);
    vec_t v;
    v.name = n; v.rst = r; v.ifv = ifv; v.ifa = ifa; v.ifr = ifr;
    v.lsv = lsv; v.lsa = lsa; v.lsr = lsr; v.sar = sar; v.srv = srv; v.srd = srd;
    v.e_sav = esav; v.e_saa = esaa; v.e_srr = esrr; v.e_ifar = eifar; v.e_lsar = elsar;
    v.e_ifrv = eifrv; v.e_lsrv = elsrv; v.e_rd = erd;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, ifv, input logic [31:0] ifa, input logic ifr, lsv,
                       input logic [31:0] lsa, input logic lsr, sar, srv, input logic [63:0] srd);
    rst             = r;
    ifu_bus.arvalid = ifv;
    ifu_bus.araddr  = ifa;
    ifu_bus.rready  = ifr;
    lsu_bus.arvalid = lsv;
    lsu_bus.araddr  = lsa;
    lsu_bus.rready  = lsr;
    mem_bus.arready = sar;
    mem_bus.rvalid  = srv;
    mem_bus.rdata   = srd;
  endtask

  function automatic logic [165:0] outs();
    return {mem_bus.arvalid, mem_bus.araddr, mem_bus.rready, ifu_bus.arready, lsu_bus.arready,
            ifu_bus.rvalid, lsu_bus.rvalid, ifu_bus.rdata, lsu_bus.rdata};
  endfunction

  task automatic chk(input string nm, input logic [165:0] act, input logic [165:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic exp_own[4];
  int   idx, last_hs, rv_cnt, g, if_i, ls_i;
  logic own;

  initial begin
    //   name            rst ifv ifa ifr lsv lsa lsr sar srv srd  | sav saa srr ifar lsar ifrv lsrv rd
    add("rst_out",       H, H, A0, H, L, Z,  L, H, H, D0,  L, Z,  L, L, L, L, L, ZD);
    add("if_idle",       L, H, A0, H, L, Z,  L, L, L, ZD,  L, Z,  L, L, L, L, L, ZD);
    add("if_ar_w1",      L, H, A0, H, L, Z,  L, L, L, ZD,  H, A0, L, L, L, L, L, ZD);
    add("if_ar_w2",      L, H, A0, H, L, Z,  L, L, L, ZD,  H, A0, L, L, L, L, L, ZD);
    add("if_ar_hs",      L, H, A0, H, L, Z,  L, H, L, ZD,  H, A0, L, H, L, L, L, ZD);
    add("if_r_wait",     L, L, Z,  H, L, Z,  L, L, L, D2,  L, Z,  H, L, L, L, L, D2);
    add("if_r_data",     L, L, Z,  H, L, Z,  L, L, H, D0,  L, Z,  H, L, L, H, L, D0);
    add("pri_idle",      L, H, A4, H, H, LA, H, L, L, ZD,  L, Z,  L, L, L, L, L, ZD);
    add("pri_ls_ar",     L, H, A4, H, H, LA, H, H, L, ZD,  H, LA, L, L, H, L, L, ZD);
    add("pri_ls_r",      L, H, A4, H, L, Z,  H, L, H, D1,  L, Z,  H, L, L, L, H, D1);
    add("pri_if_idle",   L, H, A4, H, L, Z,  H, L, L, ZD,  L, Z,  L, L, L, L, L, ZD);
    add("pri_if_ar",     L, H, A4, H, L, Z,  H, H, L, ZD,  H, A4, L, H, L, L, L, ZD);
    add("pri_if_r",      L, L, Z,  H, L, Z,  H, L, H, D2,  L, Z,  H, L, L, H, L, D2);
    add("bp_idle",       L, L, Z,  H, H, LB, L, L, L, ZD,  L, Z,  L, L, L, L, L, ZD);
    add("bp_ar",         L, L, Z,  H, H, LB, L, H, L, ZD,  H, LB, L, L, H, L, L, ZD);
    add("bp_hold0",      L, L, Z,  H, L, Z,  L, L, H, D3,  L, Z,  L, L, L, L, H, D3);
    add("bp_hold1",      L, L, Z,  H, L, Z,  L, L, H, D3,  L, Z,  L, L, L, L, H, D3);
    add("bp_hold2",      L, L, Z,  H, L, Z,  L, L, H, D3,  L, Z,  L, L, L, L, H, D3);
    add("bp_done",       L, L, Z,  H, L, Z,  H, L, H, D3,  L, Z,  H, L, L, L, H, D3);
    add("bp_idle2",      L, L, Z,  H, L, Z,  H, L, H, D3,  L, Z,  L, L, L, L, L, ZD);
    add("rst_idle",      L, H, A8, H, L, Z,  L, L, L, ZD,  L, Z,  L, L, L, L, L, ZD);
    add("rst_ar",        L, H, A8, H, L, Z,  L, H, L, ZD,  H, A8, L, H, L, L, L, ZD);
    add("rst_in_r",      H, L, Z,  H, L, Z,  L, L, L, D1,  L, Z,  H, L, L, L, L, D1);
    add("post_rst_idle", L, H, AC, H, L, Z,  L, H, H, D0,  L, Z,  L, L, L, L, L, ZD);
    add("post_rst_ar",   L, H, AC, H, L, Z,  L, H, L, ZD,  H, AC, L, H, L, L, L, ZD);
    add("post_rst_r",    L, L, Z,  H, L, Z,  L, L, H, D0,  L, Z,  H, L, L, H, L, D0);
    add("viol_idle",     L, L, Z,  L, H, LB, H, L, L, ZD,  L, Z,  L, L, L, L, L, ZD);
    add("viol_ar",       L, L, Z,  L, L, LB, H, H, L, ZD,  L, LB, L, L, H, L, L, ZD);
    add("viol_back",     L, L, Z,  L, L, Z,  H, H, H, D1,  L, Z,  L, L, L, L, L, ZD);
    add("late_idle",     L, H, A0, H, L, Z,  L, L, L, ZD,  L, Z,  L, L, L, L, L, ZD);
    add("late_ar_wait",  L, H, A0, H, H, LA, H, L, L, ZD,  H, A0, L, L, L, L, L, ZD);
    add("late_ar_hs",    L, H, A0, H, H, LA, H, H, L, ZD,  H, A0, L, H, L, L, L, ZD);
    add("late_r",        L, L, Z,  H, H, LA, H, L, H, D1,  L, Z,  H, L, L, H, L, D1);
    add("late_ls_idle",  L, L, Z,  H, H, LA, H, L, L, ZD,  L, Z,  L, L, L, L, L, ZD);
    add("late_ls_ar",    L, L, Z,  H, H, LA, H, H, L, ZD,  H, LA, L, L, H, L, L, ZD);
    add("late_ls_r",     L, L, Z,  H, L, Z,  H, L, H, D2,  L, Z,  H, L, L, L, H, D2);
    add("end_idle",      L, L, Z,  L, L, Z,  L, L, L, ZD,  L, Z,  L, L, L, L, L, ZD);

`ifdef MEM_RD_ARB_RR_EN
    exp_own = '{OWN_LS, OWN_IF, OWN_LS, OWN_IF};
`else
    exp_own = '{OWN_LS, OWN_LS, OWN_LS, OWN_LS};
`endif

    drive(H, L, Z, L, L, Z, L, L, L, ZD);
    repeat (2) @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].ifv, vecs[i].ifa, vecs[i].ifr, vecs[i].lsv, vecs[i].lsa,
            vecs[i].lsr, vecs[i].sar, vecs[i].srv, vecs[i].srd);
      @(negedge clk);
      chk(vecs[i].name, outs(),
          {vecs[i].e_sav, vecs[i].e_saa, vecs[i].e_srr, vecs[i].e_ifar, vecs[i].e_lsar,
           vecs[i].e_ifrv, vecs[i].e_lsrv, vecs[i].e_rd, vecs[i].e_rd});
      next_cycle();
    end

    // IFU streams 8 sequential reads into a zero-wait slave.
    idx = 0; last_hs = 0; rv_cnt = 0;
    for (int cyc = 0; cyc < 27; cyc++) begin
      drive(L, logic'(idx < 8), A0 + 32'(idx * 4), H, L, Z, L, H, H, 64'hC0DE_0000_0000_0000 | 64'(cyc));
      @(negedge clk);
      if (ifu_bus.rvalid) rv_cnt++;
      if (mem_bus.arvalid && mem_bus.arready) begin
        chk($sformatf("stream_addr%0d", idx), 166'(mem_bus.araddr), 166'(A0 + 32'(idx * 4)));
        if (idx > 0) chk($sformatf("stream_gap%0d", idx), 166'(cyc - last_hs), 166'(3));
        last_hs = cyc;
        idx++;
      end
      next_cycle();
    end
    chk("stream_count", 166'(idx), 166'(8));
    chk("stream_rvalid", 166'(rv_cnt), 166'(8));

    // Both masters request continuously for four reads.
    g = 0; if_i = 0; ls_i = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      drive(L, logic'(g < 4), 32'h8000_0100 + 32'(if_i * 4), H,
            logic'(g < 4), 32'h8000_3000 + 32'(ls_i * 4), H, H, H, D1);
      @(negedge clk);
      chk($sformatf("both_excl%0d", cyc), 166'(ifu_bus.arready & lsu_bus.arready), 166'(0));
      if (mem_bus.arvalid && mem_bus.arready && g < 4) begin
        own = lsu_bus.arready ? OWN_LS : OWN_IF;
        chk($sformatf("both_grant%0d", g), 166'(own), 166'(exp_own[g]));
        chk($sformatf("both_addr%0d", g), 166'(mem_bus.araddr),
            166'((own == OWN_LS) ? 32'h8000_3000 + 32'(ls_i * 4) : 32'h8000_0100 + 32'(if_i * 4)));
        if (own == OWN_LS) ls_i++;
        else if_i++;
        g++;
      end
      next_cycle();
    end
    chk("both_count", 166'(g), 166'(4));

    drive(L, L, Z, L, L, Z, L, L, L, ZD);
    repeat (2) next_cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
